// File: rtl/cla_pkg.sv
// ============================================================================
// Module      : cla_pkg
// Description : Shared types for the nibble-serial carry-lookahead sequencer:
//               nibble width, nibble type and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/cla_nibble_seq.sv
// ============================================================================
// Module      : cla_nibble_seq
// Description : Multi-cycle WIDTH-bit adder sequencer. Feeds an external 4-bit
//               CLA stage one operand nibble plus running carry per cycle and
//               collects the sum nibbles and final carry-out.
//               Optional macro CLA_SELFCHECK_EN adds a sticky chk_err output
//               that flags any CLA stage result disagreeing with a local adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output nibble_t          cla_a,
  output nibble_t          cla_b,
  output logic             cla_cin,
  input  nibble_t          cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int NIBBLES = WIDTH / NIB_W;
  // At least one index bit even for a single-nibble adder.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIBBLES - 1);

  seq_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;

  // Bit offset of the active nibble: idx * 4.
  logic [IDX_W+1:0] w_base;
  assign w_base = {r_idx, 2'b00};

  // Drive the CLA stage only while running; handshake flags follow the state.
  always_comb begin
    cla_a     = '0;
    cla_b     = '0;
    cla_cin   = 1'b0;
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_sum   = '0;
    out_cout  = 1'b0;
    if (r_state == RUN) begin
      cla_a   = r_a[w_base +: NIB_W];
      cla_b   = r_b[w_base +: NIB_W];
      cla_cin = r_carry;
    end
    if (r_state == DONE) begin
      out_sum  = r_sum;
      out_cout = r_carry;
    end
  end

  // Sequencer: accept operands, collect one nibble per RUN cycle, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: NIB_W] <= cla_sum;
          r_carry                <= cla_cout;
          if (r_idx == c_LAST_IDX) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CLA_SELFCHECK_EN
  logic [NIB_W:0] w_ref_sum;
  assign w_ref_sum = {1'b0, cla_a} + {1'b0, cla_b} + {{NIB_W{1'b0}}, cla_cin};

  // Sticky flag: any RUN cycle where the CLA stage disagrees with the reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if ((r_state == RUN) && ({cla_cout, cla_sum} != w_ref_sum)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
- Multi-cycle WIDTH-bit adder sequencer that drives an external 4-bit carry-lookahead adder stage.
- Each cycle it feeds the stage one operand nibble and the running carry, then captures the stage's sum nibble and carry-out.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Lets the team build wide adders from one 4-bit CLA instance, trading latency for area.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per operation.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in for the whole operation.
cla_a  output  4  nibble of A to the CLA stage.
cla_b  output  4  nibble of B to the CLA stage.
cla_cin  output  1  running carry to the CLA stage.
cla_sum  input  4  sum nibble from the CLA stage (combinational return).
cla_cout  input  1  carry-out from the CLA stage.
out_valid  output  1  result available.
out_ready  input  1  sink accepts result.
out_sum  output  WIDTH  result sum.
out_cout  output  1  final carry-out.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n.
- While rst_n is low at a clock edge, the block resets to:
  - state=IDLE, idx=0, carry=0, a_reg=b_reg=sum_reg=0.
  - out_valid=0, out_sum=0, out_cout=0.
- in_ready=1 in the first cycle after reset.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, capture in_a, in_b into a_reg, b_reg, set carry=in_cin and idx=0, then go to RUN.
  - RUN: in_ready=0. Drive combinationally:
    - cla_a = a_reg[4*idx+3:4*idx]
    - cla_b = b_reg[4*idx+3:4*idx]
    - cla_cin = carry
  - On each RUN edge: sum_reg nibble idx <= cla_sum, carry <= cla_cout, idx <= idx+1.
  - On the edge where idx==NIBBLES-1, go to DONE instead of incrementing.
  - DONE: out_valid=1, out_sum=sum_reg, out_cout=carry. Hold both stable until an edge with out_ready=1, then go to IDLE.
- Outside RUN, cla_a, cla_b and cla_cin are all 0.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge.
- Throughput: one operation per NIBBLES+2 cycles at best; there is one IDLE bubble after the result handshake.
- in_valid is ignored outside IDLE; the source must hold its operands until the handshake.
- out_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE) aborts the operation with no output. The next cycle is IDLE with all outputs at their reset values.
- The block does no arithmetic itself apart from the idx increment. Carry propagates only through cla_cout.
- WIDTH=4: exactly one RUN cycle.

Optional Feature:
CLA_SELFCHECK_EN
- Defined:
  - Adds output port chk_err (1 bit).
  - Every RUN cycle, the block compares {cla_cout, cla_sum} against the internal 5-bit sum cla_a + cla_b + cla_cin.
  - On any mismatch chk_err goes to 1 on that edge and stays set until reset. Reset value is 0.
  - The result path still uses the values from the CLA stage.
- Not defined: no chk_err port and no comparison logic.

Decomposition:
- Package cla_pkg holds:
  - NIB_W=4.
  - typedef nibble_t (4-bit).
  - State enum seq_state_t {IDLE, RUN, DONE}.
- No sub-module. The CLA stage is instantiated beside this block by the parent and wired through the cla_* ports.
- Nibble select is an indexed part-select inside this module.

Test Plan:
- All scenarios use WIDTH=16. The bench drives cla_sum and cla_cout from a correct behavioural 4-bit adder unless stated.
- Basic add: in_a=0x1234, in_b=0x4321, in_cin=0 → out_sum=0x5555, out_cout=0, out_valid exactly 4 cycles after accept.
- Full carry ripple: 0xFFFF+0x0001, cin=0 → cla_cin sequence 0,1,1,1 → out_sum=0x0000, out_cout=1.
- Carry-in only: 0x0000+0x0000, cin=1 → out_sum=0x0001, out_cout=0.
- Backpressure: out_ready held low 3 cycles in DONE → out_valid, out_sum and out_cout stable, in_ready=0, a concurrent in_valid is ignored. After out_ready=1, the next cycle shows in_ready=1.
- Reset mid-RUN: rst_n low after 2 RUN edges → next cycle state IDLE, out_valid=0, in_ready=1, cla_*=0. A following 0x00FF+0x0001 gives 0x0100, cout 0.
- With CLA_SELFCHECK_EN: the bench model flips cla_sum bit 0 on nibble 2 → chk_err=1 from that edge, still 1 after the next clean operation, cleared only by reset.
